// File: rtl/text_entry_ctrl.sv
// Keyboard text-entry controller: edge-detected keycodes are written into an external text RAM
// with backspace editing; ENTER hands off to the game. Optional macro TEXT_ENTRY_CLEAR_EN adds a RAM-clear pass.
module text_entry_ctrl #(
  parameter int MAX_LEN    = 8,
  parameter int KEY_W      = 8,
  parameter int ENTER_CODE = 40,
  parameter int BKSP_CODE  = 42,
  parameter int ADDR_W     = $clog2(MAX_LEN)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [KEY_W-1:0]  keycode,
  input  logic              game_end,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [KEY_W-1:0]  wdata,
  output logic [ADDR_W:0]   len,
  output logic              buf_full,
  output logic              game_enable,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    GAME  = 2'd1,
    FIN   = 2'd2,
    CLEAR = 2'd3
  } state_t;

`ifdef TEXT_ENTRY_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = ENTRY;
`endif

  localparam logic [KEY_W-1:0] ENTER_KEY = KEY_W'(ENTER_CODE);
  localparam logic [KEY_W-1:0] BKSP_KEY  = KEY_W'(BKSP_CODE);
  localparam logic [ADDR_W:0]  FULL_LEN  = (ADDR_W+1)'(MAX_LEN);

  state_t              cur, nxt;
  logic [KEY_W-1:0]    key_prev;
  logic                new_press;
  logic                we_n;
  logic [ADDR_W-1:0]   waddr_n;
  logic [KEY_W-1:0]    wdata_n;
  logic [ADDR_W:0]     len_n;
  logic [ADDR_W:0]     len_dec;
`ifdef TEXT_ENTRY_CLEAR_EN
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_n;
`endif

  // A held key or a direct switch between two nonzero codes is not a press
  assign new_press = (keycode != '0) && (key_prev == '0);
  assign len_dec   = len - 1'b1;
  assign buf_full  = (len == FULL_LEN);
  assign state     = cur;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cur         <= RESET_STATE;
      key_prev    <= '0;
      we          <= 1'b0;
      waddr       <= '0;
      wdata       <= '0;
      len         <= '0;
      game_enable <= 1'b0;
`ifdef TEXT_ENTRY_CLEAR_EN
      clr_cnt     <= '0;
`endif
    end else begin
      cur         <= nxt;
      key_prev    <= keycode;
      we          <= we_n;
      waddr       <= waddr_n;
      wdata       <= wdata_n;
      len         <= len_n;
      game_enable <= (nxt == GAME);
`ifdef TEXT_ENTRY_CLEAR_EN
      clr_cnt     <= clr_cnt_n;
`endif
    end
  end

  always_comb begin
    nxt     = cur;
    we_n    = 1'b0;
    waddr_n = waddr;
    wdata_n = wdata;
    len_n   = len;
`ifdef TEXT_ENTRY_CLEAR_EN
    clr_cnt_n = clr_cnt;
`endif
    case (cur)
      ENTRY: begin
        if (new_press) begin
          if (keycode == ENTER_KEY) begin
            nxt = GAME;
          end else if (keycode == BKSP_KEY) begin
            if (len != '0) begin
              we_n    = 1'b1;
              waddr_n = len_dec[ADDR_W-1:0];
              wdata_n = '0;
              len_n   = len_dec;
            end
          end else if (len < FULL_LEN) begin
            we_n    = 1'b1;
            waddr_n = len[ADDR_W-1:0];
            wdata_n = keycode;
            len_n   = len + 1'b1;
          end
        end
      end
      GAME: begin
        if (game_end) nxt = FIN;
      end
      FIN: begin
        // Only a fresh ENTER restarts, so the key that committed entry cannot retrigger
        if (new_press && (keycode == ENTER_KEY)) begin
          len_n = '0;
`ifdef TEXT_ENTRY_CLEAR_EN
          nxt       = CLEAR;
          clr_cnt_n = '0;
`else
          nxt       = ENTRY;
`endif
        end
      end
`ifdef TEXT_ENTRY_CLEAR_EN
      CLEAR: begin
        we_n    = 1'b1;
        waddr_n = clr_cnt;
        wdata_n = '0;
        len_n   = '0;
        if (clr_cnt == ADDR_W'(MAX_LEN - 1)) begin
          clr_cnt_n = '0;
          nxt       = ENTRY;
        end else begin
          clr_cnt_n = clr_cnt + 1'b1;
        end
      end
`endif
      default: nxt = ENTRY;
    endcase
  end

endmodule

// File: tb/tb_text_entry_ctrl.sv
// Bench for text_entry_ctrl: directed key sequences, a behavioural model checked every cycle,
// and literal expectations on the captured write log. Honours TEXT_ENTRY_CLEAR_EN if defined.
module tb_text_entry_ctrl;

  localparam int MAX_LEN = 8;
  localparam int KEY_W   = 8;
  localparam int ADDR_W  = 3;
  localparam int ENTER   = 40;
  localparam int BKSP    = 42;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic [KEY_W-1:0]  keycode = '0;
  logic              game_end = 1'b0;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [KEY_W-1:0]  wdata;
  logic [ADDR_W:0]   len;
  logic              buf_full;
  logic              game_enable;
  logic [1:0]        state;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int wlog[$];

  // Model: mode 0=ENTRY 1=GAME 2=FIN 3=CLEAR; expected registered outputs
  int m_mode, m_len, m_prev, m_clr;
  int e_we, e_waddr, e_wdata;

  text_entry_ctrl #(
    .MAX_LEN(MAX_LEN), .KEY_W(KEY_W), .ENTER_CODE(ENTER), .BKSP_CODE(BKSP)
  ) dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .game_end(game_end),
    .we(we), .waddr(waddr), .wdata(wdata), .len(len), .buf_full(buf_full),
    .game_enable(game_enable), .state(state)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int key, input bit gend, input bit rst, input int cycles);
    keycode  = KEY_W'(key);
    game_end = gend;
    Reset    = rst;
    repeat (cycles) @(negedge Clk);
  endtask

  task automatic modelWrite(input int addr, input int data);
    e_we    = 1;
    e_waddr = addr;
    e_wdata = data;
  endtask

  always @(posedge Clk) begin
    if (Reset) begin
`ifdef TEXT_ENTRY_CLEAR_EN
      m_mode = 3;
`else
      m_mode = 0;
`endif
      m_len = 0; m_prev = 0; m_clr = 0;
      e_we = 0; e_waddr = 0; e_wdata = 0;
      chk_en = 1'b1;
    end else begin
      bit press;
      int key;
      key   = int'(keycode);
      press = (key != 0) && (m_prev == 0);
      e_we  = 0;
      case (m_mode)
        0: if (press) begin
          if (key == ENTER) m_mode = 1;
          else if (key == BKSP) begin
            if (m_len > 0) begin m_len--; modelWrite(m_len, 0); end
          end else if (m_len < MAX_LEN) begin
            modelWrite(m_len, key); m_len++;
          end
        end
        1: if (game_end) m_mode = 2;
        2: if (press && key == ENTER) begin
          m_len = 0;
`ifdef TEXT_ENTRY_CLEAR_EN
          m_mode = 3; m_clr = 0;
`else
          m_mode = 0;
`endif
        end
        default: begin
          modelWrite(m_clr, 0);
          m_len = 0;
          m_clr = (m_clr + 1) % MAX_LEN;
          if (m_clr == 0) m_mode = 0;
        end
      endcase
      m_prev = key;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      checkOutput("we", int'(we), e_we);
      if (e_we != 0) begin
        checkOutput("waddr", int'(waddr), e_waddr);
        checkOutput("wdata", int'(wdata), e_wdata);
      end
      checkOutput("len", int'(len), m_len);
      checkOutput("buf_full", int'(buf_full), int'(m_len == MAX_LEN));
      checkOutput("game_enable", int'(game_enable), int'(m_mode == 1));
      checkOutput("state", int'(state), m_mode);
      if (we) wlog.push_back(int'(waddr) * 256 + int'(wdata));
    end
  end

  task automatic resetAndSettle();
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, MAX_LEN + 2);
    wlog.delete();
  endtask

  initial begin
    applyStimulus(0, 0, 1, 2);
    checkOutput("reset_we", int'(we), 0);
    checkOutput("reset_len", int'(len), 0);
    applyStimulus(0, 0, 0, MAX_LEN + 2);
    wlog.delete();

    // Two held presses give exactly two writes
    applyStimulus(4, 0, 0, 3); applyStimulus(0, 0, 0, 2);
    applyStimulus(5, 0, 0, 3); applyStimulus(0, 0, 0, 2);
    checkOutput("t1_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      checkOutput("t1_w0", wlog[0], 4);
      checkOutput("t1_w1", wlog[1], 256 + 5);
    end
    checkOutput("t1_len", int'(len), 2);

    // Overfill: presses 9 and 10 are dropped
    resetAndSettle();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(10 + i, 0, 0, 1); applyStimulus(0, 0, 0, 1);
    end
    checkOutput("t2_count", wlog.size(), 8);
    if (wlog.size() == 8) checkOutput("t2_w7", wlog[7], 7 * 256 + 17);
    checkOutput("t2_len", int'(len), 8);
    checkOutput("t2_full", int'(buf_full), 1);

    // Backspace editing down to empty and beyond
    resetAndSettle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4 + i, 0, 0, 1); applyStimulus(0, 0, 0, 1);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(BKSP, 0, 0, 2); applyStimulus(0, 0, 0, 1);
    end
    checkOutput("t3_len1", int'(len), 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(BKSP, 0, 0, 2); applyStimulus(0, 0, 0, 1);
    end
    checkOutput("t3_len0", int'(len), 0);
    checkOutput("t3_count", wlog.size(), 6);
    if (wlog.size() == 6) begin
      checkOutput("t3_w3", wlog[3], 2 * 256);
      checkOutput("t3_w4", wlog[4], 1 * 256);
      checkOutput("t3_w5", wlog[5], 0);
    end

    // Rollover from one key to another without release
    resetAndSettle();
    applyStimulus(4, 0, 0, 2); applyStimulus(5, 0, 0, 2); applyStimulus(0, 0, 0, 2);
    checkOutput("t4_count", wlog.size(), 1);
    if (wlog.size() == 1) checkOutput("t4_w0", wlog[0], 4);
    checkOutput("t4_len", int'(len), 1);

    // ENTER -> GAME, keys ignored, game_end -> FIN, held ENTER does not restart
    wlog.delete();
    applyStimulus(ENTER, 0, 0, 2);
    checkOutput("t5_state_game", int'(state), 1);
    checkOutput("t5_ge", int'(game_enable), 1);
    applyStimulus(0, 0, 0, 1); applyStimulus(4, 0, 0, 2); applyStimulus(0, 0, 0, 1);
    applyStimulus(ENTER, 0, 0, 2);
    checkOutput("t5_nowrite", wlog.size(), 0);
    checkOutput("t5_still_game", int'(state), 1);
    applyStimulus(ENTER, 1, 0, 2);
    applyStimulus(ENTER, 0, 0, 3);
    checkOutput("t5_state_fin", int'(state), 2);
    checkOutput("t5_len_kept", int'(len), 1);
    applyStimulus(0, 0, 0, 1); applyStimulus(ENTER, 0, 0, 1); applyStimulus(0, 0, 0, 1);
    checkOutput("t5_len_cleared", int'(len), 0);
`ifdef TEXT_ENTRY_CLEAR_EN
    applyStimulus(0, 0, 0, MAX_LEN + 1);
    checkOutput("t5_clear_count", wlog.size(), MAX_LEN);
`endif
    checkOutput("t5_state_entry", int'(state), 0);

    // Reset while a write is on the bus
    applyStimulus(6, 0, 0, 1);
    checkOutput("t6_we_before", int'(we), 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("t6_we", int'(we), 0);
    checkOutput("t6_len", int'(len), 0);
    checkOutput("t6_key_prev", int'(dut.key_prev), 0);
`ifdef TEXT_ENTRY_CLEAR_EN
    checkOutput("t6_state", int'(state), 3);
    applyStimulus(0, 0, 0, 3);
    applyStimulus(7, 0, 1, 1);
    checkOutput("t6_clr_we", int'(we), 0);
    checkOutput("t6_clr_state", int'(state), 3);
    applyStimulus(0, 0, 0, MAX_LEN + 2);
`else
    checkOutput("t6_state", int'(state), 0);
    applyStimulus(0, 0, 0, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_entry_ctrl.md
Name: text_entry_ctrl

Overview:
- Parametrised keyboard text-entry controller for the text_drawing front end.
- Captures up to MAX_LEN keycodes into an external name/text RAM, with backspace editing and a press/release edge detector, then hands off to the game on ENTER.
- Sits between the USB keycode register and the text RAM and game logic; generalises the fixed 8-character entry FSM.

Parameters:
- MAX_LEN, 8, maximum stored characters (>=2).
- KEY_W, 8, keycode width.
- ENTER_CODE, 40, keycode that commits entry and restarts after game end.
- BKSP_CODE, 42, keycode that deletes the last character.
- ADDR_W, $clog2(MAX_LEN), RAM address width (derived).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- keycode  in  KEY_W  current key; 0 = no key.
- game_end  in  1  game-over pulse/level from game logic.
- we  out  1  RAM write strobe, one cycle per write.
- waddr  out  ADDR_W  RAM write address.
- wdata  out  KEY_W  RAM write data.
- len  out  ADDR_W+1  characters currently stored (0..MAX_LEN).
- buf_full  out  1  len == MAX_LEN.
- game_enable  out  1  high while in GAME.
- state  out  2  encoding: ENTRY=0, GAME=1, FIN=2, CLEAR=3.

Behaviour:
- Reset values: state ENTRY (CLEAR if macro defined), we=0, waddr=0, wdata=0, len=0, game_enable=0, key_prev=0.
- The clear counter also resets to 0.
- Edge detect: key_prev <= keycode every cycle.
- new_press = (keycode!=0) && (key_prev==0).
- A held key, or a change from one nonzero code to another without an intervening 0, is not a new press.
- All outputs are registered. A new_press sampled at edge N produces we=1 during cycle N+1 only. len updates at the same edge as we.
- ENTRY, new_press with keycode==ENTER_CODE:
  - Go to GAME. No write; len is kept.
  - ENTER with len=0 is allowed.
- ENTRY, new_press with keycode==BKSP_CODE:
  - If len>0: write waddr=len-1, wdata=0, then len--.
  - If len==0: ignored, no write.
- ENTRY, new_press with any other code:
  - If len<MAX_LEN: write waddr=len, wdata=keycode, then len++.
  - If full: ignored, no write, len unchanged.
- GAME: game_enable=1. Keys are ignored. game_end=1 -> FIN on the next edge.
- FIN:
  - game_end is ignored.
  - new_press with ENTER_CODE -> ENTRY (macro off) or CLEAR (macro on), and len<=0.
  - An ENTER still held from entry does not retrigger (edge-based).
- ENTRY ignores game_end. GAME ignores all keycodes, including ENTER.
- Reset mid-operation (any state, including mid-CLEAR) returns to the reset values on the next edge. Any in-flight write is dropped.
- buf_full is combinational from registered len.

Optional Feature:
- Macro TEXT_ENTRY_CLEAR_EN.
- Defined:
  - Adds the CLEAR state, entered from reset and from FIN on ENTER.
  - CLEAR writes wdata=0 to addresses 0..MAX_LEN-1, one per cycle with we=1: MAX_LEN cycles, counter wraps to 0, then ENTRY.
  - Keys are ignored during CLEAR; key_prev still tracks.
  - len=0 throughout.
- Not defined:
  - CLEAR is unreachable; state code 3 is never output.
  - Reset and FIN go directly to ENTRY. Old RAM contents persist and the draw logic masks them with len.

Test Plan:
1. Reset, then press/release 'A'(4), 'B'(5), each held 3 cycles -> exactly two we pulses: (0,4) then (1,5); len=2.
2. Press 10 distinct keys with MAX_LEN=8 -> 8 writes at addr 0..7; presses 9 and 10 give no we; buf_full=1, len=8.
3. Enter 3 chars, press BKSP(42) twice, then BKSP four more times -> writes (2,0),(1,0); len=1, then 0; the further BKSPs produce no writes.
4. Press 4, then switch keycode to 5 without releasing, then release -> only write (0,4); len=1.
5. From ENTRY press ENTER(40) -> state=1, game_enable=1; press 4 in GAME -> no we; game_end=1 -> state=2; ENTER still held -> stays FIN; release and re-press ENTER -> len=0, state ENTRY (macro off) or 8 zero writes at addr 0..7 then ENTRY (macro on).
6. Assert Reset in the 3rd cycle of CLEAR or mid-write -> next cycle we=0, len=0, key_prev=0, state at its reset value.
